// File: rtl/int_controller.sv
// Nesting, prioritised interrupt controller with a return-address stack and
// bus-visible mask/pending/enable registers. Channel 0 has the highest priority.
module int_controller #(
  parameter int unsigned         WIDTH         = 16,
  parameter int unsigned         CHANNELS      = 8,
  parameter logic [CHANNELS-1:0] EDGE_MASK     = '0,
  parameter int unsigned         NEST_DEPTH    = 4,
  parameter logic [WIDTH-1:0]    VECTOR_BASE   = 16'h0010,
  parameter int unsigned         VECTOR_STRIDE = 4,
  localparam int unsigned        IdW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned        CntW          = $clog2(NEST_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] irq,
  output logic                int_req,
  output logic [IdW-1:0]      int_id,
  output logic [WIDTH-1:0]    int_vector,
  input  logic                int_ack,
  input  logic [WIDTH-1:0]    ret_addr_in,
  input  logic                iret,
  output logic                ret_valid,
  output logic [WIDTH-1:0]    ret_addr_out,
  input  logic                int_mask,
  input  logic                int_unmask,
  input  logic [1:0]          reg_sel,
  input  logic                reg_write,
  input  logic [WIDTH-1:0]    reg_wdata,
  output logic [WIDTH-1:0]    reg_rdata,
  output logic                stack_err
);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [CHANNELS-1:0] irq_q;
  logic                enable_q, enable_d;
  logic                stack_err_q, stack_err_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [IdW-1:0]      int_id_q, int_id_d;
  logic [WIDTH-1:0]    int_vector_q, int_vector_d;
  logic                ret_valid_q, ret_valid_d;
  logic [WIDTH-1:0]    ret_addr_q, ret_addr_d;
  logic [WIDTH-1:0]    stack_addr_q [NEST_DEPTH];
  logic [WIDTH-1:0]    stack_addr_d [NEST_DEPTH];
  logic [IdW-1:0]      stack_id_q [NEST_DEPTH];
  logic [IdW-1:0]      stack_id_d [NEST_DEPTH];

  logic [IdW-1:0]      top_id;
  logic [WIDTH-1:0]    top_addr;
  logic                stack_empty, stack_full;
  logic [CHANNELS-1:0] eligible;
  logic                any_eligible;
  logic [IdW-1:0]      sel_id;
  logic                push, pop;
  logic [CHANNELS-1:0] ack_clr, w1c_clr, edge_set;
  logic                unused_wdata;

  assign unused_wdata = ^reg_wdata;

  assign stack_empty = (count_q == '0);
  assign stack_full  = (count_q == CntW'(NEST_DEPTH));

  always_comb begin
    top_id   = '0;
    top_addr = '0;
    for (int i = 0; i < int'(NEST_DEPTH); i++) begin
      if (count_q == CntW'(i + 1)) begin
        top_id   = stack_id_q[i];
        top_addr = stack_addr_q[i];
      end
    end
  end

  // Only channels strictly more urgent than the one in service may nest.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      eligible[i] = pending_q[i] & mask_q[i] & (stack_empty | (IdW'(i) < top_id));
    end
  end

  always_comb begin
    sel_id = '0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (eligible[i]) sel_id = IdW'(i);
    end
  end

  assign any_eligible = |eligible;

  // iret has precedence over a coincident ack; the ack is simply dropped.
  assign pop  = iret && !stack_empty;
  assign push = (state_q == StReq) && int_ack && !iret && enable_q;

  always_comb begin
    state_d      = state_q;
    int_id_d     = int_id_q;
    int_vector_d = int_vector_q;
    case (state_q)
      StIdle: begin
        if (enable_q && !stack_full && any_eligible) begin
          state_d      = StReq;
          int_id_d     = sel_id;
          int_vector_d = VECTOR_BASE + WIDTH'(sel_id) * WIDTH'(VECTOR_STRIDE);
        end
      end
      StReq: begin
        if (!enable_q || push) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ack_clr = '0;
    if (push) ack_clr[int_id_q] = 1'b1;
    w1c_clr  = (reg_write && reg_sel == 2'd1) ? reg_wdata[CHANNELS-1:0] : '0;
    edge_set = irq & ~irq_q;
    // Edge set wins over a same-cycle clear; level channels just track irq.
    pending_d = (EDGE_MASK & ((pending_q & ~(ack_clr | w1c_clr)) | edge_set)) |
                (~EDGE_MASK & irq);
  end

  always_comb begin
    mask_d      = mask_q;
    enable_d    = enable_q;
    stack_err_d = stack_err_q;
    if (reg_write && reg_sel == 2'd0) mask_d = reg_wdata[CHANNELS-1:0];
    if (int_unmask) enable_d = 1'b1;
    if (int_mask)   enable_d = 1'b0;
    if (reg_write && reg_sel == 2'd2) begin
      enable_d = reg_wdata[0];
      if (reg_wdata[1]) stack_err_d = 1'b0;
    end
    if (iret && stack_empty) stack_err_d = 1'b1;
  end

  always_comb begin
    stack_addr_d = stack_addr_q;
    stack_id_d   = stack_id_q;
    count_d      = count_q;
    if (push) begin
      for (int i = 0; i < int'(NEST_DEPTH); i++) begin
        if (count_q == CntW'(i)) begin
          stack_addr_d[i] = ret_addr_in;
          stack_id_d[i]   = int_id_q;
        end
      end
      count_d = count_q + CntW'(1);
    end else if (pop) begin
      count_d = count_q - CntW'(1);
    end
    ret_valid_d = pop;
    ret_addr_d  = pop ? top_addr : ret_addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      mask_q       <= '0;
      pending_q    <= '0;
      irq_q        <= '0;
      enable_q     <= 1'b0;
      stack_err_q  <= 1'b0;
      count_q      <= '0;
      int_id_q     <= '0;
      int_vector_q <= '0;
      ret_valid_q  <= 1'b0;
      ret_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      pending_q    <= pending_d;
      irq_q        <= irq;
      enable_q     <= enable_d;
      stack_err_q  <= stack_err_d;
      count_q      <= count_d;
      int_id_q     <= int_id_d;
      int_vector_q <= int_vector_d;
      ret_valid_q  <= ret_valid_d;
      ret_addr_q   <= ret_addr_d;
    end
  end

  // Entries above count_q are don't-care, so the storage needs no reset.
  always_ff @(posedge clk) begin
    stack_addr_q <= stack_addr_d;
    stack_id_q   <= stack_id_d;
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_sel)
      2'd0: reg_rdata = WIDTH'(mask_q);
      2'd1: reg_rdata = WIDTH'(pending_q);
      2'd2: begin
        reg_rdata[0]         = enable_q;
        reg_rdata[1]         = stack_err_q;
        reg_rdata[2 +: CntW] = count_q;
      end
      default: begin
        reg_rdata[IdW-1:0]   = top_id;
        reg_rdata[WIDTH-1]   = stack_empty;
      end
    endcase
  end

  assign int_req      = (state_q == StReq);
  assign int_id       = int_id_q;
  assign int_vector   = int_vector_q;
  assign ret_valid    = ret_valid_q;
  assign ret_addr_out = ret_addr_q;
  assign stack_err    = stack_err_q;

endmodule

// File: tb/tb_int_controller.sv
// Directed bench: instance a uses default parameters, instance b uses
// EDGE_MASK=0x01 and NEST_DEPTH=2; both share the same stimulus.
module tb_int_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq;
  logic        int_ack, iret, int_mask, int_unmask, reg_write;
  logic [15:0] ret_addr_in, reg_wdata;
  logic [1:0]  reg_sel;

  logic        a_int_req, a_ret_valid, a_stack_err;
  logic [2:0]  a_int_id;
  logic [15:0] a_int_vector, a_ret_addr_out, a_reg_rdata;
  logic        b_int_req, b_ret_valid, b_stack_err;
  logic [2:0]  b_int_id;
  logic [15:0] b_int_vector, b_ret_addr_out, b_reg_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  int_controller u_dut_a (
    .clk(clk), .rst(rst), .irq(irq),
    .int_req(a_int_req), .int_id(a_int_id), .int_vector(a_int_vector),
    .int_ack(int_ack), .ret_addr_in(ret_addr_in), .iret(iret),
    .ret_valid(a_ret_valid), .ret_addr_out(a_ret_addr_out),
    .int_mask(int_mask), .int_unmask(int_unmask),
    .reg_sel(reg_sel), .reg_write(reg_write), .reg_wdata(reg_wdata),
    .reg_rdata(a_reg_rdata), .stack_err(a_stack_err)
  );

  int_controller #(
    .EDGE_MASK (8'h01),
    .NEST_DEPTH(2)
  ) u_dut_b (
    .clk(clk), .rst(rst), .irq(irq),
    .int_req(b_int_req), .int_id(b_int_id), .int_vector(b_int_vector),
    .int_ack(int_ack), .ret_addr_in(ret_addr_in), .iret(iret),
    .ret_valid(b_ret_valid), .ret_addr_out(b_ret_addr_out),
    .int_mask(int_mask), .int_unmask(int_unmask),
    .reg_sel(reg_sel), .reg_write(reg_write), .reg_wdata(reg_wdata),
    .reg_rdata(b_reg_rdata), .stack_err(b_stack_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic [1:0] sel);
    reg_sel = sel;
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [15:0] data);
    reg_write = 1'b1;
    reg_sel   = sel;
    reg_wdata = data;
    tick();
    reg_write = 1'b0;
    reg_wdata = '0;
  endtask

  task automatic chk_a_req(input string tag, input logic req, input logic [2:0] id);
    check({tag, "_req"}, 32'(a_int_req), 32'(req));
    if (req) check({tag, "_id"}, 32'(a_int_id), 32'(id));
  endtask

  initial begin
    rst = 1'b1; irq = '0; int_ack = 0; iret = 0; int_mask = 0; int_unmask = 0;
    reg_write = 0; reg_wdata = '0; reg_sel = '0; ret_addr_in = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_req",    32'(a_int_req),      32'd0);
    check("rst_id",     32'(a_int_id),       32'd0);
    check("rst_vec",    32'(a_int_vector),   32'd0);
    check("rst_rvalid", 32'(a_ret_valid),    32'd0);
    check("rst_raddr",  32'(a_ret_addr_out), 32'd0);
    check("rst_err",    32'(a_stack_err),    32'd0);
    set_sel(2'd2);
    check("rst_sel2",   32'(a_reg_rdata),    32'd0);

    // Priority and latency
    wr(2'd0, 16'h00FF);
    wr(2'd2, 16'h0001);
    irq = 8'h24;
    tick();
    check("lat_e0_req", 32'(a_int_req), 32'd0);
    tick();
    chk_a_req("prio", 1'b1, 3'd2);
    check("prio_vec", 32'(a_int_vector), 32'h0018);

    // Level source dropping during REQ keeps the request
    irq = 8'h20;
    tick();
    chk_a_req("hold", 1'b1, 3'd2);
    int_ack = 1; ret_addr_in = 16'h0AAA;
    tick();
    int_ack = 0;
    check("ack_low", 32'(a_int_req), 32'd0);
    set_sel(2'd3);
    check("tos_id", 32'(a_reg_rdata), 32'h0002);
    set_sel(2'd2);
    check("sel2_one", 32'(a_reg_rdata), 32'h0005);
    tick();
    check("ch5_blk_by2", 32'(a_int_req), 32'd0);
    iret = 1;
    tick();
    iret = 0;
    check("pop0_valid", 32'(a_ret_valid), 32'd1);
    check("pop0_addr",  32'(a_ret_addr_out), 32'h0AAA);
    tick();
    check("pop0_pulse", 32'(a_ret_valid), 32'd0);
    chk_a_req("ch5", 1'b1, 3'd5);
    check("ch5_vec", 32'(a_int_vector), 32'h0024);

    // Nesting
    int_ack = 1; ret_addr_in = 16'h1234;
    tick();
    int_ack = 0;
    irq = 8'h62;
    tick();
    tick();
    chk_a_req("nest_ch1", 1'b1, 3'd1);
    check("nest_vec", 32'(a_int_vector), 32'h0014);
    int_ack = 1; ret_addr_in = 16'h2000;
    tick();
    int_ack = 0;
    tick();
    irq = 8'h40;
    check("ch6_blk_by1", 32'(a_int_req), 32'd0);
    iret = 1;
    tick();
    iret = 0;
    check("iret1_valid", 32'(a_ret_valid), 32'd1);
    check("iret1_addr",  32'(a_ret_addr_out), 32'h2000);
    tick();
    check("ch6_blk_by5", 32'(a_int_req), 32'd0);
    iret = 1;
    tick();
    iret = 0;
    check("iret2_valid", 32'(a_ret_valid), 32'd1);
    check("iret2_addr",  32'(a_ret_addr_out), 32'h1234);
    tick();
    chk_a_req("ch6", 1'b1, 3'd6);
    check("ch6_vec", 32'(a_int_vector), 32'h0028);

    // iret + ack together: pop only, request stays up
    int_ack = 1; ret_addr_in = 16'h0600; irq = 8'h08;
    tick();
    int_ack = 0;
    tick();
    chk_a_req("sim_ch3", 1'b1, 3'd3);
    iret = 1; int_ack = 1; ret_addr_in = 16'h3333;
    tick();
    iret = 0; int_ack = 0;
    check("sim_valid", 32'(a_ret_valid), 32'd1);
    check("sim_addr",  32'(a_ret_addr_out), 32'h0600);
    chk_a_req("sim_still", 1'b1, 3'd3);
    set_sel(2'd2);
    check("sim_sel2", 32'(a_reg_rdata), 32'h0001);

    // mask + unmask together: mask wins; enable drop withdraws request
    int_mask = 1; int_unmask = 1;
    tick();
    int_mask = 0; int_unmask = 0;
    set_sel(2'd2);
    check("mask_win", 32'(a_reg_rdata), 32'h0000);
    tick();
    check("en_drop", 32'(a_int_req), 32'd0);
    int_mask = 1;
    wr(2'd2, 16'h0001);
    int_mask = 0;
    set_sel(2'd2);
    check("wr_override", 32'(a_reg_rdata), 32'h0001);

    // Build two stacked entries with a live request, then reset
    tick();
    chk_a_req("rb_ch3", 1'b1, 3'd3);
    int_ack = 1; ret_addr_in = 16'h0300; irq = 8'h06;
    tick();
    int_ack = 0;
    tick();
    chk_a_req("rb_ch1", 1'b1, 3'd1);
    int_ack = 1; ret_addr_in = 16'h0100; irq = 8'h01;
    tick();
    int_ack = 0;
    tick();
    chk_a_req("rb_ch0", 1'b1, 3'd0);
    set_sel(2'd2);
    check("rb_sel2", 32'(a_reg_rdata), 32'h0009);
    rst = 1'b1;
    #1;
    check("mrst_req",    32'(a_int_req),      32'd0);
    check("mrst_id",     32'(a_int_id),       32'd0);
    check("mrst_vec",    32'(a_int_vector),   32'd0);
    check("mrst_rvalid", 32'(a_ret_valid),    32'd0);
    check("mrst_raddr",  32'(a_ret_addr_out), 32'd0);
    check("mrst_err",    32'(a_stack_err),    32'd0);
    check("mrst_sel2",   32'(a_reg_rdata),    32'd0);
    set_sel(2'd3);
    check("mrst_sel3",   32'(a_reg_rdata),    32'h8000);
    irq = '0;
    tick();
    rst = 1'b0;
    tick();

    // Edge mode on channel 0 (instance b)
    wr(2'd0, 16'h00FF);
    wr(2'd2, 16'h0001);
    irq = 8'h01;
    tick();
    check("edge_e0", 32'(b_int_req), 32'd0);
    tick();
    check("edge_req", 32'(b_int_req), 32'd1);
    check("edge_id",  32'(b_int_id), 32'd0);
    check("edge_vec", 32'(b_int_vector), 32'h0010);
    int_ack = 1; ret_addr_in = 16'h0A00;
    tick();
    int_ack = 0;
    check("edge_ack1", 32'(b_int_req), 32'd0);
    set_sel(2'd1);
    check("edge_pend_clr", 32'(b_reg_rdata), 32'h0000);
    int_ack = 1;
    tick();
    int_ack = 0;
    tick();
    check("edge_ack2", 32'(b_int_req), 32'd0);
    iret = 1;
    tick();
    iret = 0;
    check("edge_pop_v", 32'(b_ret_valid), 32'd1);
    check("edge_pop_a", 32'(b_ret_addr_out), 32'h0A00);
    tick();
    check("edge_once", 32'(b_int_req), 32'd0);

    // W1C on the edge channel
    int_mask = 1; irq = 8'h00;
    tick();
    int_mask = 0; irq = 8'h01;
    tick();
    set_sel(2'd1);
    check("w1c_pre", 32'(b_reg_rdata), 32'h0001);
    wr(2'd1, 16'h0001);
    set_sel(2'd1);
    check("w1c_post", 32'(b_reg_rdata), 32'h0000);

    // Stack full / empty (instance b, depth 2)
    irq = 8'h09; int_unmask = 1;
    tick();
    int_unmask = 0;
    tick();
    check("full_ch3",  32'(b_int_req), 32'd1);
    check("full_id3",  32'(b_int_id), 32'd3);
    check("full_vec3", 32'(b_int_vector), 32'h001C);
    int_ack = 1; ret_addr_in = 16'h3000; irq = 8'h05;
    tick();
    int_ack = 0;
    tick();
    check("full_id2", 32'(b_int_id), 32'd2);
    int_ack = 1; ret_addr_in = 16'h2000; irq = 8'h04;
    tick();
    int_ack = 0; irq = 8'h05;
    tick();
    tick();
    check("full_blk", 32'(b_int_req), 32'd0);
    set_sel(2'd1);
    check("full_pend", 32'(b_reg_rdata), 32'h0005);
    set_sel(2'd2);
    check("full_sel2", 32'(b_reg_rdata), 32'h0009);
    iret = 1;
    tick();
    iret = 0;
    check("full_pop_v", 32'(b_ret_valid), 32'd1);
    check("full_pop_a", 32'(b_ret_addr_out), 32'h2000);
    check("full_pop_r", 32'(b_int_req), 32'd0);
    tick();
    check("resume_req", 32'(b_int_req), 32'd1);
    check("resume_id",  32'(b_int_id), 32'd0);
    iret = 1;
    tick();
    check("last_pop_v", 32'(b_ret_valid), 32'd1);
    check("last_pop_a", 32'(b_ret_addr_out), 32'h3000);
    tick();
    iret = 0;
    check("empty_noval", 32'(b_ret_valid), 32'd0);
    check("empty_req",   32'(b_int_req), 32'd1);
    check("empty_err",   32'(b_stack_err), 32'd1);
    set_sel(2'd2);
    check("empty_sel2",  32'(b_reg_rdata), 32'h0003);
    wr(2'd2, 16'h0003);
    set_sel(2'd2);
    check("err_clr",     32'(b_reg_rdata), 32'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/int_controller.md
# int_controller

Parametrised, nesting interrupt controller for the CPU, generalising the single `io_interrupt` line into CHANNELS prioritised sources. It latches requests, selects the highest-priority enabled source, and hands the control unit a vector address. It saves return addresses on an internal nesting stack and supplies them back on interrupt return. It sits between IO devices and the control unit, and its mask/pending registers are reachable over the data bus.

## Interface
- WIDTH, 16: data/address width; CHANNELS <= WIDTH.
- CHANNELS, 8: interrupt sources; index 0 = highest priority.
- EDGE_MASK, all zeros (CHANNELS bits): per-channel mode, 1 = rising-edge, 0 = level.
- NEST_DEPTH, 4: return-stack depth (>= 1).
- VECTOR_BASE, 16'h0010: vector of channel 0.
- VECTOR_STRIDE, 4: vector spacing; vector = VECTOR_BASE + id*VECTOR_STRIDE, mod 2^WIDTH.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- irq  in  CHANNELS  device request lines, synchronous to clk.
- int_req  out  1  request to control unit, registered.
- int_id  out  log2(CHANNELS)  channel of current request.
- int_vector  out  WIDTH  handler address of current request.
- int_ack  in  1  control unit accepts request (1-cycle pulse).
- ret_addr_in  in  WIDTH  return address to save, sampled on accepted ack.
- iret  in  1  interrupt return (1-cycle pulse).
- ret_valid  out  1  1-cycle pulse: ret_addr_out valid.
- ret_addr_out  out  WIDTH  popped return address.
- int_mask / int_unmask  in  1  clear / set global enable.
- reg_sel  in  2  register select.
- reg_write  in  1  register write strobe.
- reg_wdata  in  WIDTH  write data.
- reg_rdata  out  WIDTH  combinational read data.
- stack_err  out  1  sticky: iret on empty stack.

## Operation
- Reset: mask, pending, enable, stack count, int_req, int_id, int_vector, ret_valid, ret_addr_out, stack_err all 0. Reset mid-operation discards pending and stack immediately.
- Pending: level channel: pending[i] <= irq[i] every cycle. Edge channel: set on irq[i] & ~irq_q[i], cleared by accepted ack of i or W1C write. Set wins over a same-cycle clear.
- Eligible channel: pending & mask, index lower than top-of-stack id (any index if stack empty).
- Requests are raised only when enable=1 and the stack is not full.
- States:
  - IDLE: if any channel is eligible, latch the lowest eligible index into int_id/int_vector and go to REQ (int_req=1).
  - REQ: int_id/int_vector frozen. On int_ack: push {ret_addr_in, int_id}, clear edge pending[int_id], go to IDLE. If enable drops, go to IDLE without push. A level source deasserting in REQ does not withdraw the request.
- iret: if stack non-empty, pop, drive ret_addr_out, pulse ret_valid. If empty, no pop, set stack_err, ret_valid stays 0.
- iret and int_ack in the same cycle: iret is processed, ack is ignored, and the FSM remains in REQ.
- int_mask and int_unmask in the same cycle: mask wins. A register write to enable in the same cycle overrides both.
- Registers, write:
  - sel 0: mask.
  - sel 1: W1C pending, edge channels only.
  - sel 2: enable = wdata[0]; write 1 to bit 1 clears stack_err.
- Registers, read:
  - sel 0: mask.
  - sel 1: pending.
  - sel 2: {stack count, stack_err, enable}, LSB-aligned.
  - sel 3: top-of-stack id, with bit WIDTH-1 = stack empty.
- Unused read bits are 0. Writes to sel 3 are ignored.

## Timing
- irq rising before edge k: pending set at k, int_req high after k+1 (2-cycle latency).
- int_ack sampled at edge m: int_req low after m. The earliest next request is after m+1.
- iret at edge n: ret_valid/ret_addr_out valid for the cycle after n only.
- Stack full (count = NEST_DEPTH): no new request. Requests resume the cycle after a pop.
- A higher-priority arrival while in REQ is served after the current ack, as a nested request.

## Test plan
- Reset: rst pulse mid-REQ with 2 stacked entries. All outputs 0; reg sel 2 reads 0.
- Priority/latency: mask=0xFF, enable=1, irq=0x24 at edge 0. int_req high after edge 1, int_id=2, int_vector=0x0018.
- Nesting: ack ch5 with ret 0x1234; raise ch1, ack with ret 0x2000; two irets. ret_addr_out 0x2000 then 0x1234. A ch6 request is blocked while ch5 is in service.
- Edge mode: EDGE_MASK=0x01; irq[0] held high through two acks. Only one request. W1C write of 0x01 clears pending.
- Full/empty: NEST_DEPTH=2; fill the stack. int_req stays 0 with ch0 pending. An iret on empty sets stack_err, with no ret_valid.
- Simultaneous: iret+int_ack in one cycle gives a pop only, with int_req still 1. int_mask+int_unmask gives enable=0.
